weight_delay_memory: RTL and testbench

//   Parametrised M x N word store for SNN synaptic weights/delays.

---
 rtl/weight_delay_memory_if.sv | 41 ++++
 rtl/weight_delay_memory.sv | 159 +++++++++++++++
 tb/tb_weight_delay_memory.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_delay_memory_if.sv
// Bus bundle for the SNN weight/delay store: write, stream, clear,
// read and flattened-array signals. clk/reset stay plain ports.
interface weight_delay_memory_if #(
  parameter int M  = 320,
  parameter int N  = 8,
  parameter int AW = 9
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          stream_start;
  logic          stream_valid;
  logic [N-1:0]  stream_data;
  logic          stream_ready;
  logic          clear_req;
  logic          commit;
  logic          busy;
  logic          load_done;
  logic          addr_err;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic [M*N-1:0] all_data_out;

  modport master (
    output wr_en, wr_addr, wr_data,
    output stream_start, stream_valid,
    output stream_data, clear_req,
    output commit, rd_addr,
    input  stream_ready, busy, load_done,
    input  addr_err, rd_data, all_data_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  stream_start, stream_valid,
    input  stream_data, clear_req,
    input  commit, rd_addr,
    output stream_ready, busy, load_done,
    output addr_err, rd_data, all_data_out
  );
endinterface

// File: rtl/weight_delay_memory.sv
// M x N synaptic weight/delay store with random write, stream load
// and clear sweep. Define SHADOW_EN for a committed output shadow.
module weight_delay_memory #(
  parameter int M  = 320,
  parameter int N  = 8,
  parameter int AW = 9
) (
  input logic clk,
  input logic reset,
  weight_delay_memory_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_CLEAR
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(M - 1);
  localparam logic [AW:0]   MLIM = (AW + 1)'(M);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          load_done_q, load_done_d;
  logic          addr_err_q, addr_err_d;

  logic [N-1:0]  mem_q [M];
  logic [N-1:0]  out_w [M];

  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok = {1'b0, bus.wr_addr} < MLIM;
  assign rd_ok = {1'b0, bus.rd_addr} < MLIM;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_done_d = load_done_q;
    addr_err_d  = 1'b0;
    we          = 1'b0;
    waddr       = ptr_q;
    wdata       = bus.stream_data;
    unique case (state_q)
      S_IDLE: begin
        if (bus.wr_en) begin
          if (wr_ok) begin
            we    = 1'b1;
            waddr = bus.wr_addr;
            wdata = bus.wr_data;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (bus.clear_req) begin
          state_d     = S_CLEAR;
          ptr_d       = '0;
          load_done_d = 1'b0;
        end else if (bus.stream_start) begin
          state_d     = S_STREAM;
          ptr_d       = '0;
          load_done_d = 1'b0;
        end
      end
      S_STREAM: begin
        if (bus.clear_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end else if (bus.stream_start) begin
          ptr_d = '0;
        end else if (bus.stream_valid) begin
          we    = 1'b1;
          waddr = ptr_q;
          wdata = bus.stream_data;
          if (ptr_q == LAST) begin
            state_d     = S_IDLE;
            ptr_d       = '0;
            load_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        we          = 1'b1;
        waddr       = ptr_q;
        wdata       = '0;
        load_done_d = 1'b0;
        if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      load_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_done_q <= load_done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

`ifdef SHADOW_EN
  // Core sees the last committed set while a new one streams in
  logic [N-1:0] shadow_q [M];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (bus.commit && state_q == S_IDLE) begin
      shadow_q <= mem_q;
    end
  end

  assign out_w = shadow_q;
`else
  assign out_w = mem_q;
`endif

  for (genvar g = 0; g < M; g++) begin : g_flat
    assign bus.all_data_out[g*N +: N] = out_w[g];
  end

  assign bus.rd_data      = rd_ok ? mem_q[bus.rd_addr] : '0;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.stream_ready = (state_q == S_STREAM);
  assign bus.load_done    = load_done_q;
  assign bus.addr_err     = addr_err_q;

endmodule

// File: tb/tb_weight_delay_memory.sv
// Directed bench for weight_delay_memory: reset, random write,
// stream load, clear sweep, abort and output visibility.
module tb_weight_delay_memory;
  localparam int M  = 320;
  localparam int N  = 8;
  localparam int AW = 9;

`ifdef SHADOW_EN
  localparam logic [7:0] PRE = 8'h00;
`else
  localparam logic [7:0] PRE = 8'h5A;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  weight_delay_memory_if #(.M(M), .N(N), .AW(AW)) bus ();

  weight_delay_memory #(.M(M), .N(N), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, output logic [N-1:0] v);
    bus.rd_addr = AW'(a);
    #1;
    v = bus.rd_data;
  endtask

  task automatic cnt_nz(output int c);
    logic [N-1:0] v;
    c = 0;
    for (int i = 0; i < M; i++) begin
      rd(i, v);
      if (v != '0) c++;
    end
  endtask

  function automatic logic [N-1:0] adw(input int i);
    return bus.all_data_out[i*N +: N];
  endfunction

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 2*M && bus.busy; k++) tick();
    chk(tag, bus.busy, 0);
  endtask

  initial begin
    logic [N-1:0] v;
    int c;
    int n;
    int bc;
    bit acc;
    bit seen_rdy;

    bus.wr_en = 0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.stream_start = 0;
    bus.stream_valid = 0;
    bus.stream_data = '0;
    bus.clear_req = 0;
    bus.commit = 0;
    bus.rd_addr = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_all", 32'(|bus.all_data_out), 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdy", bus.stream_ready, 0);
    chk("rst_done", bus.load_done, 0);
    chk("rst_aerr", bus.addr_err, 0);

    bus.wr_en = 1;
    bus.wr_addr = 9'd5;
    bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 0;
    rd(5, v);
    chk("wr5", v, 8'hA5);
    bus.wr_addr = 9'd320;
    bus.wr_data = 8'h77;
    bus.wr_en = 1;
    tick();
    bus.wr_en = 0;
    chk("aerr_hi", bus.addr_err, 1);
    tick();
    chk("aerr_lo", bus.addr_err, 0);
    cnt_nz(c);
    chk("oob_nz", c, 1);
    rd(5, v);
    chk("oob_w5", v, 8'hA5);
    rd(320, v);
    chk("rd_oob", v, 0);

    bus.stream_start = 1;
    tick();
    bus.stream_start = 0;
    chk("st_busy", bus.busy, 1);
    chk("st_rdy", bus.stream_ready, 1);
    chk("st_done0", bus.load_done, 0);
    n = 0;
    for (int cyc = 0; cyc < 4*M && n < M; cyc++) begin
      bus.stream_valid = (cyc % 2) == 1;
      bus.stream_data = N'(n);
      acc = bus.stream_valid && bus.stream_ready;
      tick();
      if (acc) n++;
    end
    bus.stream_valid = 0;
    chk("st_cnt", n, M);
    chk("st_busy_end", bus.busy, 0);
    chk("st_rdy_end", bus.stream_ready, 0);
    chk("st_done", bus.load_done, 1);
    rd(319, v);
    chk("st_w319", v, 8'h3F);
    rd(200, v);
    chk("st_w200", v, 8'hC8);
    rd(5, v);
    chk("st_w5", v, 8'h05);
    rd(0, v);
    chk("st_w0", v, 8'h00);

    bus.stream_start = 1;
    tick();
    bus.stream_start = 0;
    bus.stream_valid = 1;
    bus.stream_data = 8'hFF;
    for (int i = 0; i < M; i++) tick();
    bus.stream_valid = 0;
    chk("ff_done", bus.load_done, 1);
    rd(0, v);
    chk("ff_w0", v, 8'hFF);
    rd(319, v);
    chk("ff_w319", v, 8'hFF);

    bus.clear_req = 1;
    tick();
    bus.clear_req = 0;
    bc = 0;
    seen_rdy = 0;
    for (int k = 0; k < 2*M && bus.busy; k++) begin
      if (k == 10) begin
        bus.stream_start = 1;
        bus.wr_en = 1;
        bus.wr_addr = 9'd3;
        bus.wr_data = 8'h55;
      end else begin
        bus.stream_start = 0;
        bus.wr_en = 0;
      end
      if (bus.stream_ready) seen_rdy = 1;
      bc++;
      tick();
    end
    bus.stream_start = 0;
    bus.wr_en = 0;
    chk("clr_cycles", bc, M);
    chk("clr_no_rdy", 32'(seen_rdy), 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_done", bus.load_done, 0);
    rd(3, v);
    chk("clr_w3", v, 0);
    cnt_nz(c);
    chk("clr_nz", c, 0);

    bus.clear_req = 1;
    bus.stream_start = 1;
    tick();
    bus.clear_req = 0;
    bus.stream_start = 0;
    chk("both_busy", bus.busy, 1);
    chk("both_rdy", bus.stream_ready, 0);
    wait_idle("both_end");

    bus.stream_start = 1;
    tick();
    bus.stream_start = 0;
    bus.stream_valid = 1;
    bus.stream_data = 8'h11;
    for (int i = 0; i < 100; i++) tick();
    rd(99, v);
    chk("ab_w99", v, 8'h11);
    bus.stream_valid = 0;
    bus.clear_req = 1;
    tick();
    bus.clear_req = 0;
    chk("ab_busy", bus.busy, 1);
    chk("ab_rdy", bus.stream_ready, 0);
    chk("ab_done_mid", bus.load_done, 0);
    wait_idle("ab_end");
    chk("ab_done", bus.load_done, 0);
    rd(0, v);
    chk("ab_w0", v, 0);
    rd(99, v);
    chk("ab_w99z", v, 0);
    cnt_nz(c);
    chk("ab_nz", c, 0);

    bus.stream_start = 1;
    tick();
    bus.stream_start = 0;
    bus.stream_valid = 1;
    bus.stream_data = 8'h5A;
    tick();
    chk("vis_w0", adw(0), PRE);
    rd(0, v);
    chk("vis_rd0", v, 8'h5A);
    for (int i = 0; i < M-1; i++) tick();
    bus.stream_valid = 0;
    chk("vis_done", bus.load_done, 1);
    chk("vis_w319", adw(319), PRE);
    bus.commit = 1;
    tick();
    bus.commit = 0;
    chk("cm_w0", adw(0), 8'h5A);
    chk("cm_w319", adw(319), 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
